// File: rtl/stage1_row_loader.sv
// Row feeder for the row-DCT stage: level-shifts 8-bit pixels, converts them exactly
// to IEEE-754 singles and hands out rows of eight with a valid/ready handshake.
module stage1_row_loader #(
    parameter int unsigned LEVEL_SHIFT = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        out_ready,
    output logic [31:0] M0,
    output logic [31:0] M1,
    output logic [31:0] M2,
    output logic [31:0] M3,
    output logic [31:0] M4,
    output logic [31:0] M5,
    output logic [31:0] M6,
    output logic [31:0] M7,
    output logic        valid,
    output logic [2:0]  row_idx,
    output logic        last_row
);
    localparam logic [8:0] SHIFT = 9'(LEVEL_SHIFT);

    logic [31:0] slot [8];
    logic [31:0] row  [8];
    logic [2:0]  cnt;
    logic        collect_full;
    logic        first_row;
    logic        accept;
    logic        transfer;

    logic [8:0]  s;
    logic [8:0]  s_neg;
    logic [7:0]  mag;
    logic [2:0]  lead;
    logic [7:0]  norm;
    logic [31:0] fp;

    // Exact int->float: |s| fits in 8 bits, so the mantissa never needs rounding.
    always_comb begin
        s     = {1'b0, pix_in} - SHIFT;
        s_neg = '0 - s;
        mag   = s[8] ? s_neg[7:0] : s[7:0];
        lead  = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (mag[i]) lead = 3'(i);
        end
        norm = mag << (3'd7 - lead);
        if (mag == '0) fp = '0;
        else           fp = {s[8], 8'd127 + {5'd0, lead}, norm[6:0], 16'd0};
    end

    assign pix_ready = !collect_full;
    assign accept    = pix_valid && pix_ready;
    assign transfer  = collect_full && (!valid || out_ready);
    assign last_row  = valid && (row_idx == 3'd7);

    always_ff @(posedge clk) begin
        if (accept) slot[cnt] <= fp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            collect_full <= 1'b0;
            valid        <= 1'b0;
            row_idx      <= '0;
            first_row    <= 1'b1;
            for (int unsigned i = 0; i < 8; i++) row[i] <= '0;
        end else begin
            if (accept) begin
                cnt <= cnt + 3'd1;
                if (cnt == 3'd7) collect_full <= 1'b1;
            end
            // accept and transfer are mutually exclusive: one needs !full, the other full.
            if (transfer) begin
                for (int unsigned i = 0; i < 8; i++) row[i] <= slot[i];
                valid        <= 1'b1;
                collect_full <= 1'b0;
                first_row    <= 1'b0;
                if (!first_row) row_idx <= row_idx + 3'd1;
            end else if (valid && out_ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign M0 = row[0];
    assign M1 = row[1];
    assign M2 = row[2];
    assign M3 = row[3];
    assign M4 = row[4];
    assign M5 = row[5];
    assign M6 = row[6];
    assign M7 = row[7];
endmodule

// File: tb/tb_stage1_row_loader.sv
// Self-checking bench for stage1_row_loader: constant vectors, handshake corner
// sequences and a randomized run against a queue-based reference model.
module tb_stage1_row_loader;
    logic        clk = 1'b0;
    logic        reset, pix_valid, out_ready;
    logic        pix_ready, valid, last_row;
    logic [7:0]  pix_in;
    logic [31:0] M0, M1, M2, M3, M4, M5, M6, M7;
    logic [2:0]  row_idx;
    int          n_cmp = 0;
    int          n_bad = 0;

    stage1_row_loader #(.LEVEL_SHIFT(128)) dut (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .out_ready(out_ready),
        .M0(M0), .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6), .M7(M7),
        .valid(valid), .row_idx(row_idx), .last_row(last_row)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  pix [8];
        logic [31:0] exp [8];
    } vec_t;
    vec_t vecs [3];

    logic [31:0] exp_q [$];

    // Reference conversion from the arithmetic definition of a single-precision float.
    function automatic logic [31:0] ref_float(int pix);
        int s, m, p;
        logic [31:0] r;
        s = pix - 128;
        if (s == 0) return 32'h0;
        m = (s < 0) ? -s : s;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        r[31]    = (s < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((m - (1 << p)) << (23 - p));
        return r;
    endfunction

    function automatic logic [31:0] get_m(int k);
        case (k)
            0: return M0;
            1: return M1;
            2: return M2;
            3: return M3;
            4: return M4;
            5: return M5;
            6: return M6;
            default: return M7;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_pix(logic [7:0] v);
        int guard;
        pix_in    = v;
        pix_valid = 1'b1;
        guard     = 0;
        while (!pix_ready && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) chk("pix_ready_timeout", 32'(pix_ready), 32'd1);
        step();
        pix_valid = 1'b0;
    endtask

    task automatic chk_row(string name, logic [31:0] e [8], int idx);
        for (int k = 0; k < 8; k++) chk($sformatf("%s_M%0d", name, k), get_m(k), e[k]);
        chk({name, "_valid"}, 32'(valid), 32'd1);
        chk({name, "_row_idx"}, 32'(row_idx), 32'(idx));
    endtask

    initial begin
        logic [7:0]  px [8];
        logic [31:0] ea [8];
        logic [31:0] eb [8];
        logic [31:0] m0_hold, m7_hold;
        int          accepts, rows_popped;

        reset = 1'b1; pix_valid = 1'b0; pix_in = '0; out_ready = 1'b0;

        vecs[0].pix = '{8'd129, 8'd130, 8'd131, 8'd132, 8'd133, 8'd134, 8'd135, 8'd136};
        vecs[0].exp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        vecs[1].pix = '{8'd0, 8'd255, 8'd128, 8'd127, 8'd64, 8'd192, 8'd1, 8'd200};
        vecs[1].exp = '{32'hC3000000, 32'h42FE0000, 32'h00000000, 32'hBF800000,
                        32'hC2800000, 32'h42800000, 32'hC2FE0000, 32'h42900000};
        vecs[2].pix = '{8'd128, 8'd129, 8'd127, 8'd255, 8'd0, 8'd160, 8'd96, 8'd192};
        vecs[2].exp = '{32'h00000000, 32'h3F800000, 32'hBF800000, 32'h42FE0000,
                        32'hC3000000, 32'h42000000, 32'hC2000000, 32'h42800000};

        step(); step();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_row_idx", 32'(row_idx), 32'd0);
        chk("rst_M0", M0, 32'd0);
        chk("rst_M7", M7, 32'd0);
        chk("rst_last_row", 32'(last_row), 32'd0);
        reset = 1'b0; out_ready = 1'b1;
        chk("rst_pix_ready", 32'(pix_ready), 32'd1);

        // Constant vectors, one row each, consumed immediately.
        for (int v = 0; v < 3; v++) begin
            for (int k = 0; k < 8; k++) feed_pix(vecs[v].pix[k]);
            chk($sformatf("vec%0d_latency_valid", v), 32'(valid), 32'd0);
            chk($sformatf("vec%0d_full_ready", v), 32'(pix_ready), 32'd0);
            step();
            chk_row($sformatf("vec%0d", v), vecs[v].exp, v);
            chk($sformatf("vec%0d_ready_back", v), 32'(pix_ready), 32'd1);
        end
        step();
        chk("vec_consumed_valid", 32'(valid), 32'd0);

        // Backpressure: two rows while the output is stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] p;
            p = 8'(i * 13 + 7);
            if (i < 8) ea[i] = ref_float(p);
            else       eb[i - 8] = ref_float(p);
            feed_pix(p);
        end
        chk("bp_ready_low", 32'(pix_ready), 32'd0);
        chk_row("bp_rowA", ea, 3);
        m0_hold = M0; m7_hold = M7;
        for (int i = 0; i < 3; i++) step();
        chk("bp_hold_M0", M0, ea[0]);
        chk("bp_hold_M7", M7, ea[7]);
        chk("bp_hold_valid", 32'(valid), 32'd1);
        chk("bp_hold_ready", 32'(pix_ready), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk_row("bp_rowB", eb, 4);
        chk("bp_ready_back", 32'(pix_ready), 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp_drop_valid", 32'(valid), 32'd0);
        chk("bp_M0_retained", M0, eb[0]);

        // Block framing: nine rows after a fresh reset.
        reset = 1'b1; step(); reset = 1'b0;
        for (int r = 0; r < 9; r++) begin
            for (int k = 0; k < 8; k++) begin
                px[k] = 8'($urandom);
                ea[k] = ref_float(px[k]);
                feed_pix(px[k]);
            end
            step();
            chk_row($sformatf("frame_r%0d", r), ea, r % 8);
            chk($sformatf("frame_r%0d_last", r), 32'(last_row), 32'(r == 7));
        end

        // Reset in the middle of a row discards the partial row.
        for (int k = 0; k < 5; k++) feed_pix(8'(k + 10));
        reset = 1'b1;
        step();
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_row_idx", 32'(row_idx), 32'd0);
        for (int k = 0; k < 8; k++) chk($sformatf("midrst_M%0d", k), get_m(k), 32'd0);
        chk("midrst_ready", 32'(pix_ready), 32'd1);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            px[k] = 8'(200 - 17 * k);
            ea[k] = ref_float(px[k]);
            feed_pix(px[k]);
        end
        step();
        chk_row("midrst_row", ea, 0);

        // Bursty input: pix_valid alternates, valid must rise only once.
        for (int i = 0; i < 16; i++) begin
            pix_valid = (i % 2 == 0);
            pix_in    = 8'(30 * (i / 2) + 5);
            ea[i / 2] = ref_float(30 * (i / 2) + 5);
            step();
            chk($sformatf("burst_valid_c%0d", i), 32'(valid), 32'(i == 15));
        end
        pix_valid = 1'b0;
        chk_row("burst_row", ea, 1);

        // Randomized traffic against the queue model.
        reset = 1'b1; step(); reset = 1'b0;
        exp_q.delete();
        accepts = 0; rows_popped = 0;
        for (int c = 0; c < 1200; c++) begin
            logic drain;
            drain     = (c >= 1100);
            pix_valid = drain ? 1'b0 : ($urandom_range(3) != 0);
            pix_in    = 8'($urandom);
            out_ready = drain ? 1'b1 : ($urandom_range(2) != 0);
            #1;
            if (valid && out_ready) begin
                if (exp_q.size() < 8) begin
                    chk("rand_row_without_pixels", 32'(exp_q.size()), 32'd8);
                end else begin
                    for (int k = 0; k < 8; k++)
                        chk($sformatf("rand_r%0d_M%0d", rows_popped, k), get_m(k), exp_q.pop_front());
                    chk($sformatf("rand_r%0d_idx", rows_popped), 32'(row_idx), 32'(rows_popped % 8));
                    chk($sformatf("rand_r%0d_last", rows_popped), 32'(last_row),
                        32'(rows_popped % 8 == 7));
                end
                rows_popped++;
            end
            if (pix_valid && pix_ready) begin
                exp_q.push_back(ref_float(pix_in));
                accepts++;
            end
            step();
        end
        chk("rand_rows_delivered", 32'(rows_popped), 32'(accepts / 8));
        chk("rand_partial_left", 32'(exp_q.size()), 32'(accepts % 8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stage1_row_loader.md
Name: stage1_row_loader

Overview:
- Upstream feeder for the row-DCT stage of the JPEG compression pipeline.
- Accepts one 8-bit pixel per cycle and level-shifts it by subtracting LEVEL_SHIFT.
- Converts each shifted value exactly to IEEE-754 single precision and assembles 8 consecutive pixels into one row.
- Presents the row as M0..M7 with a valid/ready handshake; also tags each row with its position (0..7) inside the 8x8 block.

Parameters:
- LEVEL_SHIFT, 128, unsigned value subtracted from every pixel before conversion. Legal range 0..255.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- pix_in  input  8  unsigned pixel sample
- pix_valid  input  1  pix_in is valid this cycle
- pix_ready  output  1  block can accept a pixel this cycle
- out_ready  input  1  downstream stage accepts the presented row (wired to its en)
- M0..M7  output  32 each  IEEE-754 singles; M0 = first pixel of the row, M7 = last
- valid  output  1  M0..M7, row_idx and last_row are valid
- row_idx  output  3  row number within the current 8x8 block
- last_row  output  1  valid && row_idx==7

Behaviour:
- Reset (synchronous):
  - M0..M7=0, valid=0, row_idx=0, collect counter=0, collect_full=0.
  - Any partial row is discarded.
  - pix_ready=1 on the first cycle after reset deasserts.
- Conversion, combinational on accept:
  - s = pix_in - LEVEL_SHIFT, computed as 9-bit signed, range -255..255.
  - s==0 gives 32'h00000000 (+0.0).
  - Otherwise: sign = s<0; m = |s| (1..255); p = index of m's leading one (0..7).
  - exponent = 127+p; mantissa = m with its leading one removed, left-justified in 23 bits, low bits zero.
  - The result is exact, with no rounding and no denormals.
- Collect path:
  - Accept means pix_valid && pix_ready.
  - Each accepted pixel's float is written to collect slot[cnt], then cnt increments.
  - The accept at cnt==7 sets collect_full and wraps cnt to 0.
  - pix_ready = !collect_full (combinational, registered state only).
  - Gaps in pix_valid stall collection. Partial rows are retained indefinitely.
- Transfer:
  - Condition: collect_full && (!valid || out_ready).
  - On the transfer edge: M0..M7 <= slots 0..7, valid<=1, collect_full<=0.
  - row_idx advances when a row is transferred: it is incremented, wrapping 7->0, except on the first transfer after reset, which leaves it at 0.
  - Equivalently: row_idx counts completed handshakes (valid && out_ready) mod 8 and is applied to the next row.
- Latency:
  - Row becomes valid on the edge after the edge that accepted its 8th pixel, if the output is free.
  - With continuous input and out_ready=1, throughput is one row per 9 cycles (8 accepts + 1 full bubble).
- Output handshake:
  - While valid && !out_ready: M0..M7, row_idx and valid hold.
  - Collection continues until collect_full; then pix_ready=0.
  - valid && out_ready with no transfer in the same cycle: valid<=0. M0..M7 hold their last values.
  - valid && out_ready with a transfer in the same cycle: the new row loads and valid stays 1 (back-to-back).
- last_row: combinational, equals valid && row_idx==7. It is used downstream to close a block.
- Reset has priority over every other event. Reset mid-row or mid-stall restores the reset state in one cycle.

Test Plan:
- Conversion: LEVEL_SHIFT=128, pixels 129,130,131,132,133,134,135,136 → M0..M7 = 3F800000, 40000000, 40400000, 40800000, 40A00000, 40C00000, 40E00000, 41000000; valid rises 1 cycle after the 8th accept; row_idx=0.
- Extremes: pixels 0,255,128,127,64,192,1,200 → C3000000, 42FE0000, 00000000, BF800000, C2800000, 42800000, C2FE0000, 42900000.
- Backpressure: out_ready=0, feed 16 pixels continuously → row 1 held stable; row 2 collects; pix_ready=0 after the 16th accept. Raise out_ready for 1 cycle → row 2 appears next edge, valid stays 1, pix_ready returns to 1.
- Block framing: 64 pixels, out_ready=1 → eight rows with row_idx 0..7; last_row=1 only on the 8th row; the 9th row has row_idx=0.
- Reset mid-row: accept 5 pixels, assert reset 1 cycle, then feed 8 pixels → first output row contains only the post-reset 8 pixels; row_idx=0; outputs were 0 and valid=0 during reset.
- Bursty input: pix_valid toggling 1/0 over 16 cycles → one correct row is produced after the 8th accept; there is no spurious valid.
